// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 steering demux.
package demux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] LANE3 = 2'd3;

  function automatic logic [LANES-1:0] sel_to_onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [LANES-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding slot for a single destination lane.
// Flush wins over a write, a write wins over a drain.
module demux_lane_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_fire,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (rd_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/demux4_reg.sv
// 1-to-4 valid/ready steering demux with a registered slot per lane.
// in_ready never depends on in_valid, only on the target lane's state.
module demux4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  logic [LANES-1:0] full;
  logic [LANES-1:0] wr_en;
  logic [LANES-1:0] rd_fire;
  logic [WIDTH-1:0] data [LANES];
  logic             in_fire;

  assign in_ready = ~rst & ~flush &
                    (~full[in_sel] | out_ready[in_sel]);
  assign in_fire  = in_valid & in_ready;
  assign wr_en    = sel_to_onehot(in_sel) & {LANES{in_fire}};
  assign rd_fire  = full & out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .wr_en  (wr_en[i]),
      .wr_data(in_data),
      .rd_fire(rd_fire[i]),
      .full_o (full[i]),
      .data_o (data[i])
    );
  end

  assign out_valid = full;
  assign out_data0 = data[LANE0];
  assign out_data1 = data[LANE1];
  assign out_data2 = data[LANE2];
  assign out_data3 = data[LANE3];

endmodule
